// File: rtl/controller_pkg.sv
// Shared types and constants for the controller poller: FSM state encoding and button bit positions.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package controller_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LATCH    = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      DONE     = 3'd4
   } state_t;

   // Bit positions in buttons_1/2. Bit 7 is the first bit shifted out of the controller.
   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/controller_poller_if.sv
// Bundles the controller bus (latch, serial clock, two data lines) and the host-side poll/result signals.
// Latency: none (wiring only).
// Backpressure: none; poll_start is a strobe, and valid is a one-cycle pulse with no ready.
// Ports (master = poller side):
//   poll_start                 host -> poller, 1-cycle poll request
//   controller_clk/latch       poller -> controllers
//   controller_1/2_data_in_B   controllers -> poller, active-low serial data
//   buttons_1/2, busy, valid   poller -> host
interface controller_poller_if;
   logic       poll_start;
   logic       controller_clk;
   logic       controller_latch;
   logic       controller_1_data_in_B;
   logic       controller_2_data_in_B;
   logic [7:0] buttons_1;
   logic [7:0] buttons_2;
   logic       busy;
   logic       valid;

   modport master (
      input  poll_start, controller_1_data_in_B, controller_2_data_in_B,
      output controller_clk, controller_latch, buttons_1, buttons_2, busy, valid
   );

   modport slave (
      output poll_start, controller_1_data_in_B, controller_2_data_in_B,
      input  controller_clk, controller_latch, buttons_1, buttons_2, busy, valid
   );
endinterface

// File: rtl/controller_shift_channel.sv
// Deserialises one controller's active-low data line and presents the result as active-high buttons.
// Latency: o_buttons updates on the clock edge after i_commit is sampled high.
// Backpressure: none; the FSM in the parent decides when to sample and when to commit.
// Ports: i_clk_1, i_rst_B (async active-low), i_sample (shift enable), i_commit (load hold reg),
//        i_data_B (serial data, active-low), o_buttons (held button byte, bit7 = first bit).
module controller_shift_channel (
   input  logic       i_clk_1,
   input  logic       i_rst_B,
   input  logic       i_sample,
   input  logic       i_commit,
   input  logic       i_data_B,
   output logic [7:0] o_buttons
);

   logic [7:0] r_shift;
   logic [7:0] r_hold;

   // Shifting into the LSB leaves the first-sampled bit in bit 7 after eight samples.
   always_ff @(posedge i_clk_1 or negedge i_rst_B) begin
      if (!i_rst_B) begin
         r_shift <= 8'h00;
      end else if (i_sample) begin
         r_shift <= {r_shift[6:0], ~i_data_B};
      end
   end

   // Separate hold register so readers never observe a partially shifted byte.
   always_ff @(posedge i_clk_1 or negedge i_rst_B) begin
      if (!i_rst_B) begin
         r_hold <= 8'h00;
      end else if (i_commit) begin
         r_hold <= r_shift;
      end
   end

   assign o_buttons = r_hold;

endmodule

// File: rtl/controller_poller.sv
// Polls two NES-style controllers: latch pulse, 8 serial clocks, deserialise, commit both bytes atomically.
// Latency: poll_start accepted in cycle 0 -> valid in cycle LATCH_CYCLES + 16*HALF_PERIOD + 1.
// Backpressure: none; poll_start outside IDLE is dropped, and valid is a single-cycle pulse.
// Ports: i_clk_1 (system clock), i_rst_B (async active-low reset),
//        bus (controller_poller_if.master: poll_start, controller clk/latch/data, buttons, busy, valid).
module controller_poller
   import controller_pkg::*;
#(
   parameter int HALF_PERIOD  = 6,
   parameter int LATCH_CYCLES = 12
) (
   input  logic                  i_clk_1,
   input  logic                  i_rst_B,
   controller_poller_if.master   bus
);

   localparam int CNT_W = $clog2(max_i(HALF_PERIOD, LATCH_CYCLES) + 1);
   localparam logic [CNT_W-1:0] HP_LD  = CNT_W'(HALF_PERIOD);
   localparam logic [CNT_W-1:0] LC_LD  = CNT_W'(LATCH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       r_bit;
   logic [2:0]       w_bit_nxt;
   logic             w_sample;
   logic             w_commit;
   logic             r_ctrl_clk;
   logic             r_latch;
   logic             r_busy;
   logic             r_valid;

   // Phase counter counts down to 1; the cycle with r_cnt == 1 is the last of its phase.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_sample    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.poll_start) begin
               w_state_nxt = LATCH;
               w_cnt_nxt   = LC_LD;
               w_bit_nxt   = 3'd0;
            end
         end
         LATCH: begin
            if (r_cnt == CNT_1) begin
               w_state_nxt = SHIFT_LO;
               w_cnt_nxt   = HP_LD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_1;
            end
         end
         SHIFT_LO: begin
            if (r_cnt == CNT_1) begin
               // Data is sampled at the end of the low phase, just before the rising edge.
               w_sample    = 1'b1;
               w_state_nxt = SHIFT_HI;
               w_cnt_nxt   = HP_LD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_1;
            end
         end
         SHIFT_HI: begin
            if (r_cnt == CNT_1) begin
               if (r_bit == 3'd7) begin
                  w_state_nxt = DONE;
                  w_commit    = 1'b1;
               end else begin
                  w_state_nxt = SHIFT_LO;
                  w_cnt_nxt   = HP_LD;
                  w_bit_nxt   = r_bit + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_1;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk_1 or negedge i_rst_B) begin
      if (!i_rst_B) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
      end
   end

   // Outputs are decoded from the next state so they are glitch-free flops aligned with the state.
   always_ff @(posedge i_clk_1 or negedge i_rst_B) begin
      if (!i_rst_B) begin
         r_ctrl_clk <= 1'b0;
         r_latch    <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_ctrl_clk <= (w_state_nxt == SHIFT_HI);
         r_latch    <= (w_state_nxt == LATCH);
         r_busy     <= (w_state_nxt != IDLE);
         r_valid    <= w_commit;
      end
   end

   controller_shift_channel u_ch1 (
      .i_clk_1   (i_clk_1),
      .i_rst_B   (i_rst_B),
      .i_sample  (w_sample),
      .i_commit  (w_commit),
      .i_data_B  (bus.controller_1_data_in_B),
      .o_buttons (bus.buttons_1)
   );

   controller_shift_channel u_ch2 (
      .i_clk_1   (i_clk_1),
      .i_rst_B   (i_rst_B),
      .i_sample  (w_sample),
      .i_commit  (w_commit),
      .i_data_B  (bus.controller_2_data_in_B),
      .o_buttons (bus.buttons_2)
   );

   assign bus.controller_clk   = r_ctrl_clk;
   assign bus.controller_latch = r_latch;
   assign bus.busy             = r_busy;
   assign bus.valid            = r_valid;

endmodule

// File: tb/tb_controller_poller.sv
// Directed bench for controller_poller with behavioural models of two controller shift registers.
// Latency: n/a.
// Backpressure: n/a.
module tb_controller_poller;
   import controller_pkg::*;

   localparam int NC = 115;

   logic clk   = 1'b0;
   logic rst_B = 1'b0;
   always #5 clk = ~clk;

   controller_poller_if bus ();

   controller_poller dut (
      .i_clk_1 (clk),
      .i_rst_B (rst_B),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // Controller models: parallel load while latch is high, shift on each controller_clk rise.
   logic [7:0] press1 = 8'h00;
   logic [7:0] press2 = 8'h00;
   logic       absent = 1'b0;
   logic [7:0] sh1 = 8'hFF;
   logic [7:0] sh2 = 8'hFF;
   logic       prev_cclk = 1'b0;

   always @(posedge clk) begin
      prev_cclk <= bus.controller_clk;
      if (bus.controller_latch) begin
         sh1 <= ~press1;
         sh2 <= ~press2;
      end else if (bus.controller_clk && !prev_cclk) begin
         sh1 <= {sh1[6:0], 1'b1};
         sh2 <= {sh2[6:0], 1'b1};
      end
   end

   assign bus.controller_1_data_in_B = absent ? 1'b1 : sh1[7];
   assign bus.controller_2_data_in_B = absent ? 1'b1 : sh2[7];

   // Per-cycle traces of one poll; index = cycles after the poll_start cycle.
   logic       t_clk   [0:NC];
   logic       t_latch [0:NC];
   logic       t_busy  [0:NC];
   logic       t_valid [0:NC];
   logic [7:0] t_b1    [0:NC];
   logic [7:0] t_b2    [0:NC];

   task automatic do_poll(input logic [7:0] p1, input logic [7:0] p2, input logic abs_i,
                          input int second_at);
      press1 = p1;
      press2 = p2;
      absent = abs_i;
      @(posedge clk); #1;
      bus.poll_start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= NC; c++) begin
         bus.poll_start = (c == second_at);
         @(negedge clk);
         t_clk[c]   = bus.controller_clk;
         t_latch[c] = bus.controller_latch;
         t_busy[c]  = bus.busy;
         t_valid[c] = bus.valid;
         t_b1[c]    = bus.buttons_1;
         t_b2[c]    = bus.buttons_2;
         @(posedge clk); #1;
      end
      bus.poll_start = 1'b0;
   endtask

   function automatic int first_valid();
      for (int c = 1; c <= NC; c++) if (t_valid[c]) return c;
      return -1;
   endfunction

   function automatic int n_valid();
      int n = 0;
      for (int c = 1; c <= NC; c++) if (t_valid[c]) n++;
      return n;
   endfunction

   task automatic test_reset();
      rst_B = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.controller_clk !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", bus.controller_clk); end
      checks++; if (bus.controller_latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b expected 0", bus.controller_latch); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
      checks++; if (bus.buttons_1 !== 8'h00) begin errors++; $display("FAIL reset_b1: got %h expected 00", bus.buttons_1); end
      checks++; if (bus.buttons_2 !== 8'h00) begin errors++; $display("FAIL reset_b2: got %h expected 00", bus.buttons_2); end
      @(posedge clk); #1;
      rst_B = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_basic();
      do_poll(8'hA5, 8'h3C, 1'b0, 0);
      checks++; if (first_valid() !== 109) begin errors++; $display("FAIL basic_latency: got %0d expected 109", first_valid()); end
      checks++; if (n_valid() !== 1) begin errors++; $display("FAIL basic_nvalid: got %0d expected 1", n_valid()); end
      checks++; if (t_b1[109] !== 8'hA5) begin errors++; $display("FAIL basic_b1: got %h expected a5", t_b1[109]); end
      checks++; if (t_b2[109] !== 8'h3C) begin errors++; $display("FAIL basic_b2: got %h expected 3c", t_b2[109]); end
      checks++; if (t_busy[1] !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b expected 1", t_busy[1]); end
      checks++; if (t_busy[109] !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %b expected 1", t_busy[109]); end
      checks++; if (t_busy[110] !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", t_busy[110]); end
      checks++; if (t_b1[109][BTN_A] !== 1'b1) begin errors++; $display("FAIL basic_btn_a: got %b expected 1", t_b1[109][BTN_A]); end
   endtask

   task automatic test_waveform();
      int bad_latch = 0;
      int bad_clk   = 0;
      int rises     = 0;
      logic exp_clk;
      do_poll(8'h5A, 8'hC3, 1'b0, 0);
      for (int c = 1; c <= NC; c++) begin
         if (t_latch[c] !== ((c >= 1) && (c <= 12))) bad_latch++;
         exp_clk = ((c >= 13) && (c <= 108)) ? (((c - 13) / 6) % 2 == 1) : 1'b0;
         if (t_clk[c] !== exp_clk) bad_clk++;
         if (c > 1 && t_clk[c] === 1'b1 && t_clk[c-1] === 1'b0) rises++;
      end
      checks++; if (bad_latch !== 0) begin errors++; $display("FAIL wave_latch: got %0d bad cycles expected 0", bad_latch); end
      checks++; if (bad_clk !== 0) begin errors++; $display("FAIL wave_clk: got %0d bad cycles expected 0", bad_clk); end
      checks++; if (rises !== 8) begin errors++; $display("FAIL wave_rises: got %0d expected 8", rises); end
      checks++; if (t_b1[109] !== 8'h5A) begin errors++; $display("FAIL wave_b1: got %h expected 5a", t_b1[109]); end
      checks++; if (t_b2[109] !== 8'hC3) begin errors++; $display("FAIL wave_b2: got %h expected c3", t_b2[109]); end
   endtask

   task automatic test_ignore();
      do_poll(8'h0F, 8'hF0, 1'b0, 50);
      checks++; if (n_valid() !== 1) begin errors++; $display("FAIL ignore_nvalid: got %0d expected 1", n_valid()); end
      checks++; if (first_valid() !== 109) begin errors++; $display("FAIL ignore_latency: got %0d expected 109", first_valid()); end
      checks++; if (t_b1[109] !== 8'h0F) begin errors++; $display("FAIL ignore_b1: got %h expected 0f", t_b1[109]); end
      checks++; if (t_busy[111] !== 1'b0) begin errors++; $display("FAIL ignore_busy_after: got %b expected 0", t_busy[111]); end
   endtask

   task automatic test_hold();
      int bad = 0;
      do_poll(8'hFF, 8'h11, 1'b0, 0);
      checks++; if (t_b1[109] !== 8'hFF) begin errors++; $display("FAIL hold_setup_b1: got %h expected ff", t_b1[109]); end
      do_poll(8'h00, 8'h22, 1'b0, 0);
      for (int c = 1; c <= 108; c++) if (t_b1[c] !== 8'hFF) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL hold_during_poll: got %0d changed cycles expected 0", bad); end
      checks++; if (t_b1[109] !== 8'h00) begin errors++; $display("FAIL hold_b1_update: got %h expected 00", t_b1[109]); end
      checks++; if (t_b2[109] !== 8'h22) begin errors++; $display("FAIL hold_b2_update: got %h expected 22", t_b2[109]); end
   endtask

   task automatic test_reset_mid();
      press1 = 8'hA5;
      press2 = 8'h3C;
      absent = 1'b0;
      @(posedge clk); #1;
      bus.poll_start = 1'b1;
      @(posedge clk); #1;
      bus.poll_start = 1'b0;
      // Advance to cycle 57: inside the high phase of bit 3 (cycles 55..60).
      repeat (56) begin
         @(posedge clk); #1;
      end
      checks++; if (bus.controller_clk !== 1'b1) begin errors++; $display("FAIL mid_in_shift_hi: got %b expected 1", bus.controller_clk); end
      rst_B = 1'b0;
      #1;
      checks++; if (bus.controller_clk !== 1'b0) begin errors++; $display("FAIL mid_rst_clk: got %b expected 0", bus.controller_clk); end
      checks++; if (bus.controller_latch !== 1'b0) begin errors++; $display("FAIL mid_rst_latch: got %b expected 0", bus.controller_latch); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.buttons_1 !== 8'h00) begin errors++; $display("FAIL mid_rst_b1: got %h expected 00", bus.buttons_1); end
      checks++; if (bus.buttons_2 !== 8'h00) begin errors++; $display("FAIL mid_rst_b2: got %h expected 00", bus.buttons_2); end
      repeat (3) @(posedge clk);
      #1;
      rst_B = 1'b1;
      repeat (2) @(posedge clk);
      do_poll(8'h81, 8'h7E, 1'b0, 0);
      checks++; if (first_valid() !== 109) begin errors++; $display("FAIL mid_after_latency: got %0d expected 109", first_valid()); end
      checks++; if (t_b1[109] !== 8'h81) begin errors++; $display("FAIL mid_after_b1: got %h expected 81", t_b1[109]); end
      checks++; if (t_b2[109] !== 8'h7E) begin errors++; $display("FAIL mid_after_b2: got %h expected 7e", t_b2[109]); end
   endtask

   task automatic test_absent();
      do_poll(8'hFF, 8'hFF, 1'b1, 0);
      checks++; if (first_valid() !== 109) begin errors++; $display("FAIL absent_latency: got %0d expected 109", first_valid()); end
      checks++; if (t_b1[109] !== 8'h00) begin errors++; $display("FAIL absent_b1: got %h expected 00", t_b1[109]); end
      checks++; if (t_b2[109] !== 8'h00) begin errors++; $display("FAIL absent_b2: got %h expected 00", t_b2[109]); end
   endtask

   initial begin
      bus.poll_start = 1'b0;
      test_reset();
      test_basic();
      test_waveform();
      test_ignore();
      test_hold();
      test_reset_mid();
      test_absent();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
